// File: rtl/wb_mport_arbiter.sv
// wb_mport_arbiter: N-port access arbiter in front of the SDRAM controller core.
// Multiplexes per-port Wishbone-side requests onto one internal access channel
// using round-robin or fixed priority, with a per-grant ack quota that forces
// re-arbitration when another port is waiting.
// Optional feature: define WB_MPORT_ARB_SNOOP_EN to build the write-snoop
// broadcast (snp_*); otherwise the snoop outputs are tied to zero.
module wb_mport_arbiter #(
  parameter int PORTS    = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0,
  parameter int QUOTA    = 4
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst_n,
  // port side
  input  logic [PORTS-1:0]          p_acc_i,
  input  logic [PORTS*AW-1:0]       p_adr_i,
  input  logic [PORTS*DW-1:0]       p_dat_i,
  input  logic [PORTS*(DW/8)-1:0]   p_sel_i,
  input  logic [PORTS-1:0]          p_we_i,
  output logic [PORTS-1:0]          p_ack_o,
  output logic [DW-1:0]             p_dat_o,
  output logic [PORTS-1:0]          gnt_o,
  // controller side
  input  logic                      idle_i,
  output logic                      acc_o,
  output logic [AW-1:0]             adr_o,
  output logic [DW-1:0]             dat_o,
  output logic [(DW/8)-1:0]         sel_o,
  output logic                      we_o,
  input  logic                      ack_i,
  input  logic [DW-1:0]             dat_i,
  // write snoop broadcast
  output logic [PORTS-1:0]          snp_vld_o,
  output logic [AW-1:0]             snp_adr_o,
  output logic [DW-1:0]             snp_dat_o,
  output logic [(DW/8)-1:0]         snp_sel_o
);

  localparam int SW = DW / 8;
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int QW = (QUOTA > 0) ? $clog2(QUOTA + 1) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUOTA);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PORTS-1:0] gnt_q, gnt_d;
  logic [QW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_idx, arb_ptr, sel_idx;
  logic [PW:0]     scan;
  logic [PORTS-1:0] win;
  logic            req_g, others_req, ack_fire, quota_hit;

  assign gnt_o      = gnt_q;
  assign p_dat_o    = dat_i;
  assign req_g      = |(p_acc_i & gnt_q);
  assign others_req = |(p_acc_i & ~gnt_q);
  assign ack_fire   = ack_i & acc_o;
  assign cnt_inc    = (ack_fire && (cnt_q != QMAX)) ? cnt_q + 1'b1 : cnt_q;
  assign quota_hit  = (QUOTA != 0) && (cnt_inc == QMAX) && others_req;

  // In SWITCH the pointer moves to the old grant in the same cycle it re-arbitrates.
  assign arb_ptr = (state_q == SWITCH) ? gnt_idx : ptr_q;

  // Encode the one-hot grant into an index for the round-robin pointer.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < PORTS; i++)
      if (gnt_q[i]) gnt_idx = PW'(i);
  end

  // Winner select: scan from lowest to highest priority so the last hit wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win     = '0;
    scan    = '0;
    sel_idx = '0;
    if (ARB_MODE == 1) begin
      for (int i = PORTS - 1; i >= 0; i--)
        if (p_acc_i[i]) begin
          win    = '0;
          win[i] = 1'b1;
        end
    end else begin
      for (int k = PORTS; k >= 1; k--) begin
        scan = {1'b0, arb_ptr} + (PW + 1)'(k);
        if (scan >= (PW + 1)'(PORTS)) scan = scan - (PW + 1)'(PORTS);
        sel_idx = scan[PW-1:0];
        if (p_acc_i[sel_idx]) begin
          win          = '0;
          win[sel_idx] = 1'b1;
        end
      end
    end
  end

  // State register: FSM state, grant, quota counter and round-robin pointer.
  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!wb_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(PORTS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: grant on request, hold during back-to-back, switch on drop or quota.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if ((|p_acc_i) && idle_i) begin
          gnt_d   = win;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (!req_g || quota_hit) state_d = SWITCH;
      end
      SWITCH: begin
        if (idle_i) begin
          ptr_d = gnt_idx;
          if (|p_acc_i) begin
            gnt_d   = win;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request/ack routing and the granted-port datapath mux.
  always_comb begin
    // A reset cycle masks the request so a coincident controller ack is discarded.
    acc_o   = wb_rst_n & req_g & (state_q == BUSY);
    p_ack_o = (ack_i && acc_o) ? gnt_q : '0;
    adr_o   = '0;
    dat_o   = '0;
    sel_o   = '0;
    we_o    = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (gnt_q[i]) begin
        adr_o = adr_o | p_adr_i[i*AW +: AW];
        dat_o = dat_o | p_dat_i[i*DW +: DW];
        sel_o = sel_o | p_sel_i[i*SW +: SW];
        we_o  = we_o  | p_we_i[i];
      end
    end
  end

`ifdef WB_MPORT_ARB_SNOOP_EN
  logic [PORTS-1:0] snp_vld_q;
  logic [AW-1:0]    snp_adr_q;
  logic [DW-1:0]    snp_dat_q;
  logic [SW-1:0]    snp_sel_q;

  // Snoop strobe: one-cycle pulse to every non-granted port after an acked write.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) snp_vld_q <= '0;
    else           snp_vld_q <= (ack_fire && we_o) ? ~gnt_q : '0;
  end

  // Snoop payload: capture the acked write.
  always_ff @(posedge wb_clk) begin
    // NOTE: payload registers are not reset; they are only meaningful while snp_vld_q is set.
    if (ack_fire && we_o) begin
      snp_adr_q <= adr_o;
      snp_dat_q <= dat_o;
      snp_sel_q <= sel_o;
    end
  end

  assign snp_vld_o = snp_vld_q;
  assign snp_adr_o = snp_adr_q;
  assign snp_dat_o = snp_dat_q;
  assign snp_sel_o = snp_sel_q;
`else
  assign snp_vld_o = '0;
  assign snp_adr_o = '0;
  assign snp_dat_o = '0;
  assign snp_sel_o = '0;
`endif

endmodule
